// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction-fetch / load-store memory arbiter.
package mem_arbiter_pkg;

  typedef logic [31:0] uint32_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic [29:0] addr;
    logic        we;
    logic [3:0]  mask;
    uint32_t     wdata;
  } mem_req_t;

  localparam logic [3:0] FETCH_MASK = 4'b1111;

  // A fetch is always a full-word read with no write data.
  function automatic mem_req_t fetch_req(input logic [29:0] addr);
    mem_req_t req;
    req.addr  = addr;
    req.we    = 1'b0;
    req.mask  = FETCH_MASK;
    req.wdata = 32'd0;
    return req;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory
// port, one transaction in flight. Data side has priority; a starvation
// counter hands the port to fetch after STARVE_MAX data grants while it waits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output uint32_t     if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [3:0]  d_wmask,
  input  uint32_t     d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output uint32_t     d_rdata,
  output logic [29:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_mask,
  output uint32_t     mem_wdata,
  input  uint32_t     mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] WAIT_INIT  = 3'(MEM_LATENCY - 1);

  arb_state_t r_state;
  arb_owner_t r_owner;
  mem_req_t   r_req;
  logic [3:0] r_starve;
  logic [2:0] r_wait;

  logic w_if_gnt;
  logic w_d_gnt;
  logic w_issue;
  logic w_done;

  assign w_issue = (r_state == ISSUE);
  assign w_done  = (r_state == WAIT) && (r_wait == 3'd0);

  // Priority pick in IDLE; gated by rst_n so grants drop the instant reset asserts.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (rst_n && (r_state == IDLE)) begin
      if (if_req && (r_starve == STARVE_LIM)) begin
        w_if_gnt = 1'b1;
      end else if (d_req) begin
        w_d_gnt = 1'b1;
      end else if (if_req) begin
        w_if_gnt = 1'b1;
      end else begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
      end
    end else begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
    end
  end

  assign if_gnt = w_if_gnt;
  assign d_gnt  = w_d_gnt;

  // Transaction sequencing: IDLE -> ISSUE (command) -> WAIT (latency count) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wait  <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_if_gnt || w_d_gnt) begin
            r_state <= ISSUE;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
          r_wait  <= WAIT_INIT;
        end
        WAIT: begin
          if (r_wait == 3'd0) begin
            r_state <= IDLE;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_wait  <= 3'd0;
        end
      endcase
    end
  end

  // Capture the winner's request so the requester is free the cycle after its grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= FETCH;
      r_req   <= '{addr: 30'd0, we: 1'b0, mask: 4'd0, wdata: 32'd0};
    end else if (w_d_gnt) begin
      r_owner <= DATA;
      r_req   <= '{addr: d_addr, we: d_we, mask: d_wmask, wdata: d_wdata};
    end else if (w_if_gnt) begin
      r_owner <= FETCH;
      r_req   <= fetch_req(if_addr);
    end else begin
      r_owner <= r_owner;
      r_req   <= r_req;
    end
  end

  // Count data grants that bypassed a waiting fetch; a fetch grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
    end else if (w_if_gnt) begin
      r_starve <= 4'd0;
    end else if (w_d_gnt && if_req && (r_starve < STARVE_LIM)) begin
      r_starve <= r_starve + 4'd1;
    end else begin
      r_starve <= r_starve;
    end
  end

  // Memory command is driven only during the single ISSUE cycle.
  always_comb begin
    mem_addr  = 30'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_mask  = 4'd0;
    mem_wdata = 32'd0;
    if (w_issue) begin
      mem_addr  = r_req.addr;
      mem_read  = ~r_req.we;
      mem_write = r_req.we;
      mem_mask  = r_req.mask;
      mem_wdata = r_req.wdata;
    end else begin
      mem_addr  = 30'd0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_mask  = 4'd0;
      mem_wdata = 32'd0;
    end
  end

  // Completion strobe to the owner only; stores complete with zero data.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    if (w_done && (r_owner == FETCH)) begin
      if_rvalid = 1'b1;
      if_rdata  = mem_rdata;
    end else if (w_done && (r_owner == DATA)) begin
      d_rvalid = 1'b1;
      d_rdata  = r_req.we ? 32'd0 : mem_rdata;
    end else begin
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int NDUT = 2;
  typedef logic [159:0] vec_t;

  typedef struct {
    bit          fetch;
    bit          we;
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          exp_rd;
    bit          exp_wr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } row_t;

  logic        clk;
  logic        rst_n;
  logic        if_req    [NDUT];
  logic [29:0] if_addr   [NDUT];
  logic        d_req     [NDUT];
  logic        d_we      [NDUT];
  logic [29:0] d_addr    [NDUT];
  logic [3:0]  d_wmask   [NDUT];
  logic [31:0] d_wdata   [NDUT];
  logic [31:0] mem_rdata [NDUT];
  wire         if_gnt    [NDUT];
  wire         if_rvalid [NDUT];
  wire  [31:0] if_rdata  [NDUT];
  wire         d_gnt     [NDUT];
  wire         d_rvalid  [NDUT];
  wire  [31:0] d_rdata   [NDUT];
  wire  [29:0] mem_addr  [NDUT];
  wire         mem_read  [NDUT];
  wire         mem_write [NDUT];
  wire  [3:0]  mem_mask  [NDUT];
  wire  [31:0] mem_wdata [NDUT];

  int checks = 0;
  int errors = 0;
  row_t rows [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    mem_arbiter #(
      .MEM_LATENCY(g == 0 ? 1 : 3),
      .STARVE_MAX (g == 0 ? 4 : 2)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req[g]), .if_addr(if_addr[g]),
      .if_gnt(if_gnt[g]), .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]),
      .d_wmask(d_wmask[g]), .d_wdata(d_wdata[g]),
      .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .mem_mask(mem_mask[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int smax_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic vec_t pack(input logic ig, input logic irv, input logic [31:0] ird,
                                input logic dg, input logic drv, input logic [31:0] drd,
                                input logic [29:0] ma, input logic mr, input logic mw,
                                input logic [3:0] mm, input logic [31:0] mwd);
    return {24'd0, ig, irv, ird, dg, drv, drd, ma, mr, mw, mm, mwd};
  endfunction

  function automatic vec_t got(input int k);
    return pack(if_gnt[k], if_rvalid[k], if_rdata[k], d_gnt[k], d_rvalid[k], d_rdata[k],
                mem_addr[k], mem_read[k], mem_write[k], mem_mask[k], mem_wdata[k]);
  endfunction

  task automatic check(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle(input int k);
    if_req[k]  = 1'b0;
    if_addr[k] = 30'd0;
    d_req[k]   = 1'b0;
    d_we[k]    = 1'b0;
    d_addr[k]  = 30'd0;
    d_wmask[k] = 4'd0;
    d_wdata[k] = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) drive_idle(k);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic d_drive(input int k, input logic we, input logic [29:0] a,
                         input logic [3:0] m, input logic [31:0] wd);
    d_req[k]   = 1'b1;
    d_we[k]    = we;
    d_addr[k]  = a;
    d_wmask[k] = m;
    d_wdata[k] = wd;
  endtask

  // Transaction-level model: a grant at cycle t puts the command at t+1, the
  // response at t+1+latency, and blocks further grants until t+2+latency.
  task automatic run_random(input int k, input int ncyc);
    int lat, smax, starve, next_ok, t_g;
    bit act, own_d, ip, dp, eg_i, eg_d;
    logic m_we, dwe, irv, drv, mr, mw;
    logic [29:0] m_addr, ia, da, ma;
    logic [3:0] m_mask, dm, mm;
    logic [31:0] m_wdata, dwd, rd, ird, drd, mwd;
    lat = lat_of(k); smax = smax_of(k);
    starve = 0; next_ok = 0; t_g = 0; act = 0; own_d = 0; ip = 0; dp = 0;
    m_we = 1'b0; m_addr = 30'd0; m_mask = 4'd0; m_wdata = 32'd0;
    ia = 30'd0; da = 30'd0; dwe = 1'b0; dm = 4'd0; dwd = 32'd0;
    for (int c = 0; c < ncyc; c++) begin
      if (!ip && ($urandom_range(0, 2) == 0)) begin
        ip = 1; ia = 30'($urandom);
      end
      if (!dp && ($urandom_range(0, 1) == 0)) begin
        dp = 1; da = 30'($urandom); dwe = 1'($urandom);
        dm = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        dwd = $urandom;
      end
      if_req[k]  = ip;
      if_addr[k] = ip ? ia : 30'($urandom);
      d_req[k]   = dp;
      d_we[k]    = dp ? dwe : 1'($urandom);
      d_addr[k]  = dp ? da : 30'($urandom);
      d_wmask[k] = dp ? dm : 4'($urandom);
      d_wdata[k] = dp ? dwd : $urandom;
      rd = $urandom;
      mem_rdata[k] = rd;
      #1;
      eg_i = 0; eg_d = 0;
      if (c >= next_ok) begin
        if (dp && !(ip && (starve == smax))) eg_d = 1;
        else if (ip) eg_i = 1;
      end
      irv = 1'b0; ird = 32'd0; drv = 1'b0; drd = 32'd0;
      ma = 30'd0; mr = 1'b0; mw = 1'b0; mm = 4'd0; mwd = 32'd0;
      if (act && (c == t_g + 1)) begin
        ma = m_addr; mr = !m_we; mw = m_we; mm = m_mask; mwd = m_wdata;
      end
      if (act && (c == t_g + 1 + lat)) begin
        if (own_d) begin
          drv = 1'b1; drd = m_we ? 32'd0 : rd;
        end else begin
          irv = 1'b1; ird = rd;
        end
      end
      check($sformatf("rand%0d_c%0d", k, c), got(k),
            pack(eg_i, irv, ird, eg_d, drv, drd, ma, mr, mw, mm, mwd));
      if (eg_d || eg_i) begin
        if (eg_i) starve = 0;
        else if (ip && (starve < smax)) starve++;
        act = 1; t_g = c; next_ok = c + 2 + lat; own_d = eg_d;
        if (eg_d) begin
          m_we = dwe; m_addr = da; m_mask = dm; m_wdata = dwd; dp = 0;
        end else begin
          m_we = 1'b0; m_addr = ia; m_mask = 4'hF; m_wdata = 32'd0; ip = 0;
        end
      end
      tick();
    end
    drive_idle(k);
    repeat (6) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit gi, gd, seen;
    int cyc, last, w;

    //            fetch we addr            mask   wdata          rdata          rd wr emask  ewdata         erdata
    rows[0] = '{1'b0, 1'b0, 30'h10,       4'hF, 32'h0,         32'hDEADBEEF, 1'b1, 1'b0, 4'hF, 32'h0,         32'hDEADBEEF};
    rows[1] = '{1'b0, 1'b1, 30'h3,        4'h6, 32'h00ABCD00,  32'h55555555, 1'b0, 1'b1, 4'h6, 32'h00ABCD00,  32'h0};
    rows[2] = '{1'b1, 1'b0, 30'h3FFFFFFF, 4'h0, 32'h0,         32'h12345678, 1'b1, 1'b0, 4'hF, 32'h0,         32'h12345678};
    rows[3] = '{1'b0, 1'b1, 30'h2AAAAAAA, 4'h0, 32'hCAFEF00D,  32'h11111111, 1'b0, 1'b1, 4'h0, 32'hCAFEF00D,  32'h0};
    rows[4] = '{1'b0, 1'b0, 30'h0,        4'h3, 32'h0,         32'hA5A5A5A5, 1'b1, 1'b0, 4'h3, 32'h0,         32'hA5A5A5A5};

    // Reset: requests asserted, yet every output must read zero.
    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      drive_idle(k);
      if_req[k] = 1'b1;
      d_req[k] = 1'b1;
      mem_rdata[k] = 32'hFFFFFFFF;
    end
    @(negedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) check($sformatf("reset_outs%0d", k), got(k), 160'd0);
    tick();
    for (int k = 0; k < NDUT; k++) drive_idle(k);
    rst_n = 1'b1;
    tick();

    // Directed single transactions on the latency-1 instance.
    for (int r = 0; r < 5; r++) begin
      if (rows[r].fetch) begin
        if_req[0] = 1'b1; if_addr[0] = rows[r].addr;
        d_req[0] = 1'b0; d_we[0] = 1'b1; d_addr[0] = 30'h1234;
        d_wmask[0] = 4'h0; d_wdata[0] = 32'hFFFFFFFF;
      end else begin
        d_drive(0, rows[r].we, rows[r].addr, rows[r].mask, rows[r].wdata);
        if_req[0] = 1'b0; if_addr[0] = 30'h3FFF;
      end
      mem_rdata[0] = rows[r].rdata;
      #1;
      check($sformatf("tbl_grant[%0d]", r), got(0),
            pack(rows[r].fetch, 1'b0, 32'd0, !rows[r].fetch, 1'b0, 32'd0,
                 30'd0, 1'b0, 1'b0, 4'd0, 32'd0));
      tick();
      drive_idle(0);
      #1;
      check($sformatf("tbl_cmd[%0d]", r), got(0),
            pack(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, rows[r].addr,
                 rows[r].exp_rd, rows[r].exp_wr, rows[r].exp_mask, rows[r].exp_wdata));
      tick();
      #1;
      check($sformatf("tbl_resp[%0d]", r), got(0),
            pack(1'b0, rows[r].fetch, rows[r].fetch ? rows[r].exp_rdata : 32'd0,
                 1'b0, !rows[r].fetch, rows[r].fetch ? 32'd0 : rows[r].exp_rdata,
                 30'd0, 1'b0, 1'b0, 4'd0, 32'd0));
      tick();
      #1;
      check($sformatf("tbl_idle[%0d]", r), got(0), 160'd0);
      tick();
    end

    // Fetch arriving while busy waits for IDLE, then wins with no data request.
    d_drive(0, 1'b0, 30'h44, 4'hF, 32'd0);
    #1;
    check("busy_dgnt", {if_gnt[0], d_gnt[0]}, 2'b01);
    for (int i = 1; i <= 3; i++) begin
      tick();
      drive_idle(0);
      if_req[0] = 1'b1; if_addr[0] = 30'h88;
      #1;
      check($sformatf("busy_wait%0d", i), {if_gnt[0], d_gnt[0]}, (i == 3) ? 2'b10 : 2'b00);
    end
    tick();
    drive_idle(0);
    repeat (4) tick();

    // Starvation: both held continuously -> D,D,D,D,F repeating, 3 cycles apart.
    do_reset();
    if_req[0] = 1'b1; if_addr[0] = 30'h100;
    d_drive(0, 1'b0, 30'h200, 4'hF, 32'd0);
    cyc = 0; last = -1;
    for (int g = 0; g < 10; g++) begin
      seen = 0; w = 0; gi = 0; gd = 0;
      while (!seen && (w < 12)) begin
        #1;
        gi = if_gnt[0]; gd = d_gnt[0];
        if (gi || gd) seen = 1;
        else begin
          tick(); cyc++; w++;
        end
      end
      if (!seen) begin
        check($sformatf("starve_timeout[%0d]", g), 160'd0, 160'd1);
        break;
      end
      check($sformatf("starve_pick[%0d]", g), {gi, gd}, ((g % 5) == 4) ? 2'b10 : 2'b01);
      if (last >= 0) check($sformatf("starve_gap[%0d]", g), cyc - last, 3);
      last = cyc;
      tick(); cyc++;
    end
    drive_idle(0);
    repeat (4) tick();

    // Latency 3: fetch response 4 cycles after grant, next grant 5 cycles after.
    if_req[1] = 1'b1; if_addr[1] = 30'h77; mem_rdata[1] = 32'h0BADF00D;
    #1;
    check("lat3_grant", {if_gnt[1], d_gnt[1]}, 2'b10);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) begin
        if_req[1] = 1'b0;
        d_drive(1, 1'b0, 30'h20, 4'hF, 32'd0);
      end
      #1;
      check($sformatf("lat3_rvalid%0d", i), {if_rvalid[1], if_rdata[1]},
            (i == 4) ? {1'b1, 32'h0BADF00D} : 33'd0);
      check($sformatf("lat3_next%0d", i), d_gnt[1], (i == 5) ? 1 : 0);
    end
    tick();
    drive_idle(1);
    repeat (8) tick();

    // Reset during WAIT aborts the transaction; a fresh request wins right after.
    d_drive(1, 1'b0, 30'h40, 4'hF, 32'd0);
    mem_rdata[1] = 32'h600DCAFE;
    #1;
    check("rstwait_grant", d_gnt[1], 1);
    tick();
    drive_idle(1);
    tick();
    rst_n = 1'b0;
    d_drive(1, 1'b0, 30'h55, 4'hF, 32'd0);
    #1;
    check("rstwait_outs", got(1), 160'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rstwait_fresh", got(1),
          pack(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 30'd0, 1'b0, 1'b0, 4'd0, 32'd0));
    tick();
    drive_idle(1);
    #1;
    check("rstwait_cmd", got(1),
          pack(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 30'h55, 1'b1, 1'b0, 4'hF, 32'd0));
    for (int i = 2; i <= 4; i++) begin
      tick();
      #1;
      check($sformatf("rstwait_resp%0d", i), {d_rvalid[1], d_rdata[1]},
            (i == 4) ? {1'b1, 32'h600DCAFE} : 33'd0);
    end
    tick();
    repeat (3) tick();

    // Randomized traffic on both instances against the model.
    do_reset();
    run_random(0, 1500);
    do_reset();
    run_random(1, 1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LATENCY, default 1, read-data latency in cycles after mem_read (legal 1..8).
REQ-002 Parameter: STARVE_MAX, default 4, consecutive data grants allowed while fetch waits (legal 1..15).
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1 / if_addr  in  30  fetch request and word address.
REQ-006 if_gnt  out  1 / if_rvalid  out  1 / if_rdata  out  32  fetch grant, response strobe, read data.
REQ-007 d_req  in  1 / d_we  in  1 / d_addr  in  30 / d_wmask  in  4 / d_wdata  in  32  load/store request.
REQ-008 d_gnt  out  1 / d_rvalid  out  1 / d_rdata  out  32  data grant, completion strobe, load data.
REQ-009 mem_addr  out  30 / mem_read  out  1 / mem_write  out  1 / mem_mask  out  4 / mem_wdata  out  32  memory command.
REQ-010 mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after the mem_read cycle.

Function
REQ-011 FSM states: IDLE, ISSUE, WAIT; one transaction in flight at most.
REQ-012 IDLE: grant decided combinationally from current requests; exactly one of if_gnt/d_gnt high for one cycle, only in IDLE; no grant in ISSUE/WAIT.
REQ-013 Priority: data wins over fetch, except fetch wins when starve_cnt == STARVE_MAX.
REQ-014 starve_cnt: +1 on a data grant while if_req high; cleared on any fetch grant; never exceeds STARVE_MAX; unchanged otherwise.
REQ-015 On grant: owner, address, we, mask, wdata latched; IDLE -> ISSUE next cycle.
REQ-016 Requester holds req and payload stable until gnt; may drop or change them the cycle after.
REQ-017 ISSUE (one cycle): mem_read=!we or mem_write=we from latched request; mem_addr/mem_mask/mem_wdata from latch; fetch mask = 4'b1111, fetch never writes.
REQ-018 ISSUE -> WAIT; wait counter loaded with MEM_LATENCY-1, decrements each WAIT cycle.
REQ-019 WAIT with counter 0: owner's rvalid high for exactly one cycle, rdata = mem_rdata (loads/fetch), rdata = 0 for stores; then WAIT -> IDLE.
REQ-020 Timing: grant cycle T, command T+1, rvalid T+1+MEM_LATENCY, earliest next grant T+2+MEM_LATENCY.
REQ-021 Store with d_wmask = 4'b0000 forwarded unchanged (mem_write=1, mask 0) and acknowledged normally.
REQ-022 Outside ISSUE: mem_read, mem_write, mem_mask, mem_addr, mem_wdata all 0.
REQ-023 Non-owner rvalid/rdata always 0; owner rdata 0 except in its rvalid cycle.
REQ-024 Simultaneous if_req and d_req in IDLE resolved per REQ-013 only; losing request stays pending, no state lost.

Reset
REQ-025 rst_n low: state IDLE, starve_cnt 0, wait counter 0, latches 0, every output 0, immediately (asynchronous).
REQ-026 Reset mid-transaction aborts it: no rvalid issued for it afterwards; first grant possible in the first clock edge after rst_n rises.

Structure
REQ-027 Common package gains arb_state_t (IDLE/ISSUE/WAIT), arb_owner_t (FETCH/DATA) and mem_req_t struct {addr 30, we, mask 4, wdata 32}; uint32_t used for data buses.
REQ-028 Single module, no sub-module; priority pick is an always_comb block within it.

Verification
REQ-029 d_req load addr 0x10, mem_rdata 0xDEADBEEF, MEM_LATENCY=1 -> d_gnt T, mem_read T+1, d_rvalid with d_rdata 0xDEADBEEF T+2.
REQ-030 if_req and d_req held continuously, STARVE_MAX=4 -> grants D,D,D,D,F repeating; if_gnt every 5th grant.
REQ-031 d store addr 0x3, mask 4'b0110, wdata 0x00AB_CD00 -> mem_write one cycle, mem_mask 0110, d_rvalid with d_rdata 0.
REQ-032 MEM_LATENCY=3 fetch -> if_rvalid exactly 4 cycles after if_gnt, next grant 5 cycles after.
REQ-033 rst_n low during WAIT -> all outputs 0 at once, no rvalid after release; fresh d_req granted first cycle post-reset.
REQ-034 Requests arriving during ISSUE/WAIT -> no gnt until IDLE; pending if_req granted in IDLE when d_req absent.
